// File: rtl/receptor_serial_8p_pkg.sv
// Shared definitions for the serial byte receiver: FSM state encoding,
// default baud divisor and the frame verdict helper.
package receptor_serial_8p_pkg;

    // 50 MHz / 115200 baud
    localparam int unsigned CLKS_PER_BIT_PADRAO = 434;

    // Encodings are shared with the 16-bit receiver top; keep values fixed.
    typedef enum logic [2:0] {
        StInicial  = 3'd0,
        StStart    = 3'd1,
        StDados    = 3'd2,
        StParidade = 3'd3,
        StStop     = 3'd4,
        StFim      = 3'd5
    } estado_t;

    // Parity matches the configured sense and the stop bit is high.
    function automatic logic calc_parity_ok(input logic [7:0] dado, input logic paridade,
                                            input logic stop, input logic impar);
        return ((^{dado, paridade}) == impar) && stop;
    endfunction

endpackage

// File: rtl/receptor_serial_8p_contador_baud.sv
// Loadable baud down-counter. A load selects a full or half bit period;
// tick is high for the one cycle the count sits at zero, after which the
// counter explicitly reloads a full bit period.
module receptor_serial_8p_contador_baud #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic carregar,
    input  logic meio,
    output logic tick
);

    localparam int unsigned W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] CARGA_CHEIA = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] CARGA_MEIO  = W'(CLKS_PER_BIT / 2 - 1);

    logic [W-1:0] contagem_q;

    // Count down; reload on request or on reaching zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem_q <= '0;
        end else if (carregar) begin
            contagem_q <= meio ? CARGA_MEIO : CARGA_CHEIA;
        end else if (contagem_q == '0) begin
            contagem_q <= CARGA_CHEIA;
        end else begin
            contagem_q <= contagem_q - 1'b1;
        end
    end

    // Tick ignores the load so the FSM can use it to decide its own transition.
    always_comb begin
        tick = (contagem_q == '0);
    end

endmodule

// File: rtl/receptor_serial_8p.sv
// Asynchronous serial byte receiver: start, 8 data bits LSB first, parity,
// stop. One fim_receber strobe per completed frame with parity/framing verdict.
module receptor_serial_8p
    import receptor_serial_8p_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = CLKS_PER_BIT_PADRAO,
    parameter bit          PARIDADE_IMPAR = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dados,
    output logic       fim_receber,
    output logic       parity_ok,
    output logic       erro_frame,
    output logic       ocupado
);

    estado_t    estado_q, estado_d;
    logic       rx_meta_q, rx_s;
    logic [7:0] shift_q;
    logic [2:0] idx_q;
    logic       bit_par_q;
    logic       tick;
    logic       carregar;
    logic       meio;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s      <= rx_meta_q;
        end
    end

    // Baud timer reloads on every state change; half period for the start bit.
    assign carregar = (estado_d != estado_q);
    assign meio     = (estado_d == StStart);

    receptor_serial_8p_contador_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_contador_baud (
        .clock    (clock),
        .reset    (reset),
        .carregar (carregar),
        .meio     (meio),
        .tick     (tick)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= StInicial;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            StInicial:  if (!rx_s) estado_d = StStart;
            StStart:    if (tick) estado_d = rx_s ? StInicial : StDados;
            StDados:    if (tick && idx_q == 3'd7) estado_d = StParidade;
            StParidade: if (tick) estado_d = StStop;
            StStop:     if (tick) estado_d = StFim;
            StFim:      estado_d = StInicial;
            default:    estado_d = StInicial;
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        fim_receber = (estado_q == StFim);
        ocupado     = (estado_q != StInicial);
    end

    // Datapath: shift in data bits, capture parity, publish verdict at stop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q    <= 8'h00;
            idx_q      <= 3'd0;
            bit_par_q  <= 1'b0;
            dados      <= 8'h00;
            parity_ok  <= 1'b0;
            erro_frame <= 1'b0;
        end else begin
            case (estado_q)
                StStart: idx_q <= 3'd0;
                StDados: begin
                    if (tick) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                    end
                end
                StParidade: if (tick) bit_par_q <= rx_s;
                StStop: begin
                    if (tick) begin
                        dados      <= shift_q;
                        parity_ok  <= calc_parity_ok(shift_q, bit_par_q, rx_s, PARIDADE_IMPAR);
                        erro_frame <= ~rx_s;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_receptor_serial_8p.sv
// Bench for receptor_serial_8p: even- and odd-parity instances share the line;
// expected frames go into per-instance queues, monitors pop on each strobe.
module tb_receptor_serial_8p;

    localparam int unsigned CPB = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic rx    = 1'b1;

    logic [7:0] dados_p, dados_i;
    logic       fim_p, fim_i, pok_p, pok_i, err_p, err_i, ocu_p, ocu_i;

    always #5 clock = ~clock;

    receptor_serial_8p #(.CLKS_PER_BIT(CPB), .PARIDADE_IMPAR(1'b0)) dut_par (
        .clock(clock), .reset(reset), .rx(rx), .dados(dados_p), .fim_receber(fim_p),
        .parity_ok(pok_p), .erro_frame(err_p), .ocupado(ocu_p)
    );

    receptor_serial_8p #(.CLKS_PER_BIT(CPB), .PARIDADE_IMPAR(1'b1)) dut_impar (
        .clock(clock), .reset(reset), .rx(rx), .dados(dados_i), .fim_receber(fim_i),
        .parity_ok(pok_i), .erro_frame(err_i), .ocupado(ocu_i)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       pok;
        logic       err;
    } esperado_t;

    esperado_t fila_p[$];
    esperado_t fila_i[$];
    int        pulsos_p[$];
    int        checks = 0;
    int        errors = 0;
    int        ciclo  = 0;

    always @(posedge clock) ciclo++;

    task automatic check(input string nome, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, act, exp, ciclo);
        end
    endtask

    // Reference: count ones over data+parity; odd total means odd parity.
    function automatic esperado_t modelo(input logic [7:0] d, input logic p, input logic s,
                                         input bit impar);
        esperado_t e;
        int uns;
        uns   = $countones(d) + int'(p);
        e.d   = d;
        e.err = !s;
        e.pok = s && ((uns % 2) == (impar ? 1 : 0));
        return e;
    endfunction

    always @(negedge clock) begin
        if (reset && fim_p) begin
            pulsos_p.push_back(ciclo);
            if (fila_p.size() == 0) begin
                check("spurious_strobe_par", 1, 0);
            end else begin
                esperado_t e;
                e = fila_p.pop_front();
                check("dados_par", dados_p, e.d);
                check("parity_ok_par", pok_p, e.pok);
                check("erro_frame_par", err_p, e.err);
            end
        end
    end

    always @(negedge clock) begin
        if (reset && fim_i) begin
            if (fila_i.size() == 0) begin
                check("spurious_strobe_impar", 1, 0);
            end else begin
                esperado_t e;
                e = fila_i.pop_front();
                check("dados_impar", dados_i, e.d);
                check("parity_ok_impar", pok_i, e.pok);
                check("erro_frame_impar", err_i, e.err);
            end
        end
    end

    // All line changes happen 1 time unit after a rising edge.
    task automatic bit_serial(input logic b);
        rx = b;
        repeat (CPB) @(posedge clock);
        #1;
    endtask

    task automatic enviar(input logic [7:0] d, input logic p, input logic s);
        fila_p.push_back(modelo(d, p, s, 1'b0));
        fila_i.push_back(modelo(d, p, s, 1'b1));
        bit_serial(1'b0);
        for (int i = 0; i < 8; i++) bit_serial(d[i]);
        bit_serial(p);
        bit_serial(s);
    endtask

    task automatic ocioso(input int bits);
        for (int i = 0; i < bits; i++) bit_serial(1'b1);
    endtask

    task automatic esperar_fila;
        for (int i = 0; i < 400 && (fila_p.size() != 0 || fila_i.size() != 0); i++)
            @(posedge clock);
        #1;
        check("strobe_timeout", fila_p.size() + fila_i.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_dados"}, {dados_i, dados_p}, 0);
        check({tag, "_fim"}, {fim_i, fim_p}, 0);
        check({tag, "_parity_ok"}, {pok_i, pok_p}, 0);
        check({tag, "_erro_frame"}, {err_i, err_p}, 0);
        check({tag, "_ocupado"}, {ocu_i, ocu_p}, 0);
    endtask

    initial begin
        int n;
        int espera;
        logic [7:0] d;
        logic p, s;

        repeat (3) @(posedge clock);
        #1;
        check_reset("reset_inicial");
        reset = 1'b1;
        ocioso(2);

        // Good frame, then wrong parity bit, then framing error.
        enviar(8'hA5, 1'b0, 1'b1);
        ocioso(1);
        esperar_fila();
        enviar(8'hA5, 1'b1, 1'b1);
        ocioso(1);
        esperar_fila();
        enviar(8'h3C, 1'b0, 1'b0);
        ocioso(2);
        esperar_fila();

        // Two-cycle glitch must be rejected as a false start.
        rx = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rx = 1'b1;
        espera = 0;
        while ((ocu_p || ocu_i || espera < 2) && espera < 9) begin
            @(posedge clock);
            #1;
            espera++;
        end
        check("glitch_ocupado_clear", {ocu_i, ocu_p}, 0);
        ocioso(2);

        // Back-to-back with no idle gap; strobes 11 bit periods apart.
        n = pulsos_p.size();
        enviar(8'h12, 1'b0, 1'b1);
        enviar(8'h34, 1'b1, 1'b1);
        ocioso(1);
        esperar_fila();
        if (pulsos_p.size() >= n + 2)
            check("b2b_spacing", pulsos_p[n+1] - pulsos_p[n], 11 * CPB);
        else
            check("b2b_pulse_count", pulsos_p.size() - n, 2);

        // Reset in the middle of data bit 4 of 0xFF.
        bit_serial(1'b0);
        for (int i = 0; i < 4; i++) bit_serial(1'b1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset("reset_meio_quadro");
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        ocioso(2);
        enviar(8'h01, 1'b0, 1'b1);
        ocioso(1);
        esperar_fila();

        // Random frames; after a framing error leave the line idle long enough.
        for (int k = 0; k < 24; k++) begin
            d = 8'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            enviar(d, p, s);
            ocioso(s ? $urandom_range(0, 2) : $urandom_range(2, 3));
        end
        ocioso(1);
        esperar_fila();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
